// File: rtl/apb_cmd_sequencer.sv
// Host-side command sequencer for the APB master: buffers read/write requests
// in a small FIFO, replays them on add_o/external_wdata_o and returns responses.
module apb_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_wdata_i,
    output logic [1:0]  add_o,
    output logic [31:0] external_wdata_o,
    input  logic        ready_i,
    input  logic [31:0] rdata_i,
    output logic        rsp_valid_o,
    output logic        rsp_write_o,
    output logic        rsp_err_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_GAP    = 2'b10
    } state_t;

    state_t         state_r, state_s;
    logic [32:0]    mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic [TW-1:0]  timer_r, timer_s;
    logic [1:0]     add_r, add_s;
    logic [31:0]    wdata_r, wdata_s;
    logic           rsp_valid_r, rsp_valid_s;
    logic           rsp_write_r, rsp_write_s;
    logic           rsp_err_r, rsp_err_s;
    logic [31:0]    rsp_rdata_r, rsp_rdata_s;
    logic           push_s, pop_s, fifo_empty_s;
    logic           head_write_s;
    logic [31:0]    head_data_s;

    // Ready is derived from the registered count only, so a full FIFO never
    // accepts even when the sequencer pops in the same cycle.
    assign cmd_ready_o  = (count_r != CW'(DEPTH));
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign push_s       = cmd_valid_i && cmd_ready_o;
    assign head_write_s = mem_r[rd_ptr_r][32];
    assign head_data_s  = mem_r[rd_ptr_r][31:0];

    assign add_o            = add_r;
    assign external_wdata_o = wdata_r;
    assign rsp_valid_o      = rsp_valid_r;
    assign rsp_write_o      = rsp_write_r;
    assign rsp_err_o        = rsp_err_r;
    assign rsp_rdata_o      = rsp_rdata_r;
    assign busy_o           = (state_r != ST_IDLE) || !fifo_empty_s;

    // Command storage; contents are don't-care while the slot is empty.
    always_ff @(posedge pclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_write_i, cmd_wdata_i};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state and next-output logic for the issue FSM.
    always_comb begin
        state_s     = state_r;
        add_s       = add_r;
        wdata_s     = wdata_r;
        timer_s     = timer_r;
        rsp_valid_s = 1'b0;
        rsp_write_s = rsp_write_r;
        rsp_err_s   = rsp_err_r;
        rsp_rdata_s = rsp_rdata_r;
        pop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    add_s   = head_write_s ? 2'b11 : 2'b01;
                    wdata_s = head_write_s ? head_data_s : wdata_r;
                    timer_s = {TW{1'b0}};
                    state_s = ST_ACCESS;
                end else begin
                    add_s = 2'b00;
                end
            end
            ST_ACCESS: begin
                // ready_i takes priority over a coinciding timeout
                if (ready_i) begin
                    add_s       = 2'b00;
                    rsp_valid_s = 1'b1;
                    rsp_write_s = add_r[1];
                    rsp_err_s   = 1'b0;
                    rsp_rdata_s = add_r[1] ? rsp_rdata_r : rdata_i;
                    state_s     = ST_GAP;
                end else if (timer_r == TW'(TIMEOUT - 1)) begin
                    add_s       = 2'b00;
                    rsp_valid_s = 1'b1;
                    rsp_write_s = add_r[1];
                    rsp_err_s   = 1'b1;
                    state_s     = ST_GAP;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_GAP: begin
                add_s   = 2'b00;
                state_s = ST_IDLE;
            end
            default: begin
                add_s   = 2'b00;
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_r     <= ST_IDLE;
            add_r       <= 2'b00;
            wdata_r     <= 32'h0000_0000;
            timer_r     <= {TW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            add_r       <= add_s;
            wdata_r     <= wdata_s;
            timer_r     <= timer_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_write_r <= rsp_write_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Scoreboard bench for apb_cmd_sequencer: a behavioural slave answers each
// access after a per-command latency; responses are checked against a queue.
module tb_apb_cmd_sequencer;

    localparam int TMO = 16;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [1:0]  add_o;
    logic [31:0] external_wdata_o;
    logic        ready_i = 1'b0;
    logic [31:0] rdata_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_write_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        busy_o;

    apb_cmd_sequencer #(.DEPTH(4), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_wdata_i(cmd_wdata_i),
        .add_o(add_o), .external_wdata_o(external_wdata_o),
        .ready_i(ready_i), .rdata_i(rdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o),
        .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .busy_o(busy_o)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic w; logic [31:0] d; int lat; } iss_t;
    typedef struct { logic w; logic e; logic [31:0] r; } rsp_t;

    iss_t        iss_q[$];
    rsp_t        rsp_q[$];
    iss_t        cur;
    int          n_checks = 0;
    int          n_fail = 0;
    int          act_cnt = 0;
    int          idle_cnt = 0;
    logic        active = 1'b0;
    logic        had_prev = 1'b0;
    logic [31:0] slave_reg = 32'h0;
    logic [31:0] model_reg = 32'h0;
    logic [31:0] last_rdata = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic lat_err(input int lat);
        return (lat == 0) || (lat > TMO);
    endfunction

    // Slave model plus response monitor, sampled on the falling edge.
    always @(negedge pclk) begin
        if (preset) begin
            ready_i  = 1'b0;
            act_cnt  = 0;
            idle_cnt = 0;
            active   = 1'b0;
            had_prev = 1'b0;
            iss_q.delete();
            rsp_q.delete();
        end else begin
            if (rsp_valid_o) begin
                if (rsp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check_eq("rsp_write", 32'(rsp_write_o), 32'(r.w));
                    check_eq("rsp_err", 32'(rsp_err_o), 32'(r.e));
                    check_eq("rsp_rdata", rsp_rdata_o, r.r);
                end
            end
            if (add_o != 2'b00) begin
                if (!active) begin
                    active  = 1'b1;
                    act_cnt = 0;
                    if (had_prev) check_eq("idle_gap_ge2", 32'(idle_cnt >= 2), 32'd1);
                    if (iss_q.size() == 0) begin
                        check_eq("issue_unexpected", 32'd1, 32'd0);
                        cur = '{w: add_o[1], d: external_wdata_o, lat: 0};
                    end else begin
                        cur = iss_q.pop_front();
                        if (cur.w) check_eq("issue_wdata", external_wdata_o, cur.d);
                    end
                end
                check_eq("add_type", 32'(add_o), cur.w ? 32'd3 : 32'd1);
                act_cnt++;
                ready_i = (cur.lat != 0) && (act_cnt == cur.lat);
                if (ready_i && cur.w) slave_reg = external_wdata_o;
                rdata_i = slave_reg;
            end else begin
                if (active) begin
                    check_eq("access_len", 32'(act_cnt), lat_err(cur.lat) ? 32'(TMO) : 32'(cur.lat));
                    active   = 1'b0;
                    had_prev = 1'b1;
                    idle_cnt = 0;
                end
                ready_i = 1'b0;
                idle_cnt++;
            end
        end
    end

    // Drives one command (called at a falling edge, returns at a falling edge).
    task automatic push_cmd(input logic w, input logic [31:0] d, input int lat);
        rsp_t r;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_wdata_i = d;
        for (int n = 0; n < 400 && !cmd_ready_o; n++) @(negedge pclk);
        if (!cmd_ready_o) begin
            check_eq("push_wait", 32'd0, 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        r.w = w;
        r.e = lat_err(lat);
        if (w) begin
            r.r = last_rdata;
            if (!r.e) model_reg = d;
        end else begin
            r.r = r.e ? last_rdata : model_reg;
        end
        last_rdata = r.r;
        iss_q.push_back('{w: w, d: d, lat: lat});
        rsp_q.push_back(r);
        @(negedge pclk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!busy_o && rsp_q.size() == 0 && !active) begin
                done = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #3;
        check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check_eq("rst_add", 32'(add_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check_eq("rst_ext_wdata", external_wdata_o, 32'd0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        // single write, first issue latency
        push_cmd(1'b1, 32'h1234abcd, 2);
        check_eq("first_add_idle", 32'(add_o), 32'd0);
        @(negedge pclk);
        check_eq("first_add_issue", 32'(add_o), 32'd3);
        drain("drain_single");

        // write then read back
        push_cmd(1'b1, 32'h5678ef01, 3);
        push_cmd(1'b0, 32'h0, 1);
        drain("drain_wr_rd");

        // FIFO full while first command is stalled
        push_cmd(1'b1, 32'hdead0001, 10);
        push_cmd(1'b0, 32'h0, 2);
        push_cmd(1'b1, 32'hdead0003, 1);
        push_cmd(1'b0, 32'h0, 3);
        push_cmd(1'b1, 32'hdead0005, 2);
        check_eq("full_ready", 32'(cmd_ready_o), 32'd0);
        check_eq("full_busy", 32'(busy_o), 32'd1);
        push_cmd(1'b0, 32'h0, 1);
        drain("drain_full");

        // timeout followed by normal commands
        push_cmd(1'b0, 32'h0, 0);
        push_cmd(1'b1, 32'hcafe0042, 2);
        push_cmd(1'b0, 32'h0, 1);
        drain("drain_timeout");

        // ready exactly on the last allowed cycle, then one cycle too late
        push_cmd(1'b0, 32'h0, TMO);
        push_cmd(1'b1, 32'hbeef0016, TMO + 1);
        push_cmd(1'b0, 32'h0, 1);
        drain("drain_edge");

        // random mix
        for (int i = 0; i < 20; i++) begin
            push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, TMO + 2));
        end
        drain("drain_random");

        // reset in the middle of a write access with commands queued
        push_cmd(1'b1, 32'h0bad0bad, 0);
        push_cmd(1'b0, 32'h0, 1);
        push_cmd(1'b1, 32'h0bad0002, 1);
        for (int n = 0; n < 50 && add_o != 2'b11; n++) @(negedge pclk);
        check_eq("pre_rst_add", 32'(add_o), 32'd3);
        #2;
        preset = 1'b1;
        #1;
        check_eq("mid_rst_add", 32'(add_o), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_rsp", 32'(rsp_valid_o), 32'd0);
        @(negedge pclk);
        model_reg  = slave_reg;
        last_rdata = 32'h0;
        @(negedge pclk);
        preset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge pclk);
            check_eq("post_rst_add", 32'(add_o), 32'd0);
            check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        end

        // commands work again after reset
        push_cmd(1'b0, 32'h0, 2);
        push_cmd(1'b1, 32'h600d600d, 1);
        push_cmd(1'b0, 32'h0, 1);
        drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
